// File: rtl/wdm_pkg.sv
// Shared definitions for the write-side data mover.
// WDM_PARITY_EN selects 9-bit serial bytes (8 data bits plus even parity).
package wdm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2
  } state_e;

`ifdef WDM_PARITY_EN
  localparam int BITS_PER_BYTE = 9;
`else
  localparam int BITS_PER_BYTE = 8;
`endif

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  localparam int BIT_CNT_W = clog2(BITS_PER_BYTE);

endpackage

// File: rtl/wdm_s2p.sv
// MSB-first serial-to-parallel shifter with bit counter; flags each completed byte.
// Under WDM_PARITY_EN the ninth bit is checked as even parity over the data byte.
module wdm_s2p
  import wdm_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_start,
  input  logic       i_bit,
  output logic       o_byte_vld,
  output logic [7:0] o_byte
`ifdef WDM_PARITY_EN
  ,
  output logic       o_par_ok
`endif
);

  localparam int SR_W = BITS_PER_BYTE - 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BITS_PER_BYTE - 1);

  logic [SR_W-1:0]      r_sr;
  logic [BIT_CNT_W-1:0] r_cnt;

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_sr  <= SR_W'(i_bit);
      r_cnt <= BIT_CNT_W'(1);
    end else if (i_en) begin
      r_sr  <= {r_sr[SR_W-2:0], i_bit};
      r_cnt <= (r_cnt == LAST_BIT) ? '0 : r_cnt + 1'b1;
    end
  end

  // The final bit is used combinationally so the byte is known in its own cycle.
  assign o_byte_vld = i_en & ~i_start & (r_cnt == LAST_BIT);

`ifdef WDM_PARITY_EN
  assign o_byte   = r_sr;
  assign o_par_ok = ((^r_sr) == i_bit);
`else
  assign o_byte   = {r_sr, i_bit};
`endif

endmodule

// File: rtl/wdm.sv
// Write-side data mover: deserialises framed bits into bytes for the shared FIFO,
// dropping whole frames that cannot be stored. WDM_PARITY_EN adds per-byte parity.
module wdm
  import wdm_pkg::*;
#(
  parameter int FRAME_BYTES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bit_vld,
  input  logic             i_bit,
  input  logic             i_sof,
  input  logic             i_fifo_full,
  input  logic             i_fifo_af,
  output logic             o_fifo_wr,
  output logic [7:0]       ov_fifo_data,
  output logic             o_frame_done,
  output logic             o_ovf,
`ifdef WDM_PARITY_EN
  output logic             o_par_err,
`endif
  output logic [CNT_W-1:0] ov_drop_cnt
);

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [7:0]         r_byte_cnt;
  logic               r_wr_pend;
  logic               r_pend_last;
  logic [7:0]         r_data;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_drop_cnt;

  logic               w_sof;
  logic               w_s2p_en;
  logic               w_byte_vld;
  logic [7:0]         w_byte;
  logic               w_par_ok;
  logic               w_in_recv;
  logic               w_last_byte;
  logic               w_wr;
  logic               w_pend_fail;
  logic               w_byte_ok;
  logic               w_par_drop;
  logic               w_lost_recv;
  logic               w_admit_drop;
  logic [CNT_W:0]     w_drop_sum;
  logic [CNT_W-1:0]   w_drop_nxt;

  assign w_sof    = i_bit_vld & i_sof;
  assign w_s2p_en = i_bit_vld & (r_state != S_IDLE);

  wdm_s2p u_s2p (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (w_s2p_en),
    .i_start    (w_sof),
    .i_bit      (i_bit),
    .o_byte_vld (w_byte_vld),
    .o_byte     (w_byte)
`ifdef WDM_PARITY_EN
    ,
    .o_par_ok   (w_par_ok)
`endif
  );

`ifndef WDM_PARITY_EN
  assign w_par_ok = 1'b1;
`endif

  assign w_in_recv    = (r_state == S_RECV);
  assign w_last_byte  = (r_byte_cnt == LAST_BYTE);
  // The pending byte is committed only if the FIFO has room in the strobe cycle itself.
  assign w_wr         = r_wr_pend & ~i_fifo_full;
  assign w_pend_fail  = r_wr_pend & i_fifo_full;
  assign w_byte_ok    = w_in_recv & w_byte_vld & w_par_ok;
  assign w_par_drop   = w_in_recv & w_byte_vld & ~w_par_ok;
  assign w_lost_recv  = w_in_recv & (w_pend_fail | (w_sof & ~(r_wr_pend & r_pend_last)));
  assign w_admit_drop = w_sof & i_fifo_af;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (w_sof) begin
      w_state_nxt = i_fifo_af ? S_DROP : S_RECV;
    end else begin
      unique case (r_state)
        S_RECV: begin
          if (r_wr_pend & r_pend_last)  w_state_nxt = S_IDLE;
          else if (w_pend_fail)         w_state_nxt = S_DROP;
          else if (w_par_drop)          w_state_nxt = w_last_byte ? S_IDLE : S_DROP;
        end
        S_DROP: begin
          if (w_byte_vld & w_last_byte) w_state_nxt = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // At most two drops can land in one cycle: a lost frame plus an immediate refusal.
  always_comb begin
    w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_lost_recv)
               + (CNT_W+1)'(w_admit_drop) + (CNT_W+1)'(w_par_drop);
    w_drop_nxt = w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= '0;
      r_wr_pend   <= 1'b0;
      r_pend_last <= 1'b0;
      r_data      <= '0;
      r_ovf       <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_pend   <= w_byte_ok;
      r_pend_last <= w_byte_ok & w_last_byte;
      r_ovf       <= r_ovf | w_pend_fail;
      r_drop_cnt  <= w_drop_nxt;
      if (w_sof)           r_byte_cnt <= '0;
      else if (w_byte_vld) r_byte_cnt <= r_byte_cnt + 1'b1;
      if (w_byte_ok)       r_data <= w_byte;
    end
  end

`ifdef WDM_PARITY_EN
  logic r_par_err;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_par_err <= 1'b0;
    else       r_par_err <= r_par_err | w_par_drop;
  end
  assign o_par_err = r_par_err;
`endif

  assign o_fifo_wr    = w_wr;
  assign ov_fifo_data = r_data;
  assign o_frame_done = w_wr & r_pend_last;
  assign o_ovf        = r_ovf;
  assign ov_drop_cnt  = r_drop_cnt;

endmodule
